// File: rtl/pc_gen.sv
// Program-counter unit for the fetch stage: sequential flow, branch/jump redirects,
// ready/stall handling with redirect capture. Optional return-address stack under PC_RAS_EN.
module pc_gen #(
    parameter int                  ADDR_W    = 16,
    parameter int                  DISP_W    = 8,
    parameter logic [ADDR_W-1:0]   RESET_VEC = '0,
    parameter int                  RAS_DEPTH = 4
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              stall_i,
    input  logic              jump_i,
    input  logic              branch_i,
    input  logic [DISP_W-1:0] displacement_i,
    input  logic [ADDR_W-1:0] jump_tgt_i,
    input  logic              imem_ready_i,
    input  logic              call_i,
    input  logic              ret_i,
    output logic [ADDR_W-1:0] addr_imem_o,
    output logic              addr_valid_o,
    output logic              redirect_pend_o,
    output logic              ras_empty_o,
    output logic              ras_full_o
);

    typedef enum logic {
        BOOT = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t            state_reg, state_next;
    logic [ADDR_W-1:0] pc_reg, pc_next;
    logic              pend_reg, pend_next;
    logic [ADDR_W-1:0] pend_tgt_reg, pend_tgt_next;

    logic              in_run;
    logic              adv;
    logic              live_req;
    logic [ADDR_W-1:0] disp_ext;
    logic [ADDR_W-1:0] pc_inc;
    logic [ADDR_W-1:0] branch_tgt;
    logic [ADDR_W-1:0] redir_tgt;
    logic              ret_ok;
    logic [ADDR_W-1:0] ras_top;

    assign in_run     = (state_reg == RUN);
    assign adv        = in_run & imem_ready_i & ~stall_i;
    assign disp_ext   = ADDR_W'($signed(displacement_i));
    assign pc_inc     = pc_reg + ADDR_W'(1);
    assign branch_tgt = pc_reg + disp_ext;

`ifdef PC_RAS_EN
    localparam int PTR_W = (RAS_DEPTH > 2) ? $clog2(RAS_DEPTH) : 1;

    logic [ADDR_W-1:0] ras_mem [RAS_DEPTH];
    logic [PTR_W-1:0]  sp_reg;
    logic [PTR_W:0]    cnt_reg;
    logic              push;
    logic [PTR_W-1:0]  sp_dec;
    logic [PTR_W-1:0]  wr_idx;

    assign ras_empty_o = (cnt_reg == '0);
    assign ras_full_o  = (cnt_reg == (PTR_W+1)'(RAS_DEPTH));
    assign sp_dec      = sp_reg - PTR_W'(1);
    assign ras_top     = ras_mem[sp_dec];
    assign ret_ok      = in_run & ret_i & ~ras_empty_o;
    assign push        = in_run & jump_i & call_i;
    // A simultaneous pop+push replaces the popped slot, leaving the pointer in place
    assign wr_idx      = ret_ok ? sp_dec : sp_reg;

    always_ff @(posedge clk_i) begin
        if (push) begin
            ras_mem[wr_idx] <= pc_inc;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sp_reg  <= '0;
            cnt_reg <= '0;
        end else begin
            case ({ret_ok, push})
                2'b10: begin
                    sp_reg  <= sp_dec;
                    cnt_reg <= cnt_reg - (PTR_W+1)'(1);
                end
                2'b01: begin
                    // Circular: overwriting the oldest entry keeps occupancy saturated
                    sp_reg <= sp_reg + PTR_W'(1);
                    if (!ras_full_o) begin
                        cnt_reg <= cnt_reg + (PTR_W+1)'(1);
                    end
                end
                default: ;
            endcase
        end
    end
`else
    logic unused_ras;
    assign unused_ras  = ^{call_i, ret_i};
    assign ret_ok      = 1'b0;
    assign ras_top     = '0;
    assign ras_empty_o = 1'b1;
    assign ras_full_o  = 1'b0;
`endif

    assign live_req  = in_run & (ret_ok | jump_i | branch_i);
    assign redir_tgt = ret_ok ? ras_top : (jump_i ? jump_tgt_i : branch_tgt);

    always_comb begin
        state_next    = RUN;
        pc_next       = pc_reg;
        pend_next     = pend_reg;
        pend_tgt_next = pend_tgt_reg;
        if (adv) begin
            if (live_req) begin
                // A fresh redirect supersedes anything captured earlier
                pc_next   = redir_tgt;
                pend_next = 1'b0;
            end else if (pend_reg) begin
                pc_next   = pend_tgt_reg;
                pend_next = 1'b0;
            end else begin
                pc_next = pc_inc;
            end
        end else if (live_req) begin
            pend_next     = 1'b1;
            pend_tgt_next = redir_tgt;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg    <= BOOT;
            pc_reg       <= RESET_VEC;
            pend_reg     <= 1'b0;
            pend_tgt_reg <= '0;
        end else begin
            state_reg    <= state_next;
            pc_reg       <= pc_next;
            pend_reg     <= pend_next;
            pend_tgt_reg <= pend_tgt_next;
        end
    end

    assign addr_imem_o     = pc_reg;
    assign addr_valid_o    = in_run;
    assign redirect_pend_o = pend_reg;

endmodule

// File: doc/pc_gen.md
Name: pc_gen

Overview:
- Parametrised program-counter unit; successor to the fixed 16-bit PC.
- Generalises address and displacement width and adds a programmable reset vector.
- Adds an instruction-memory ready handshake, a stall input, and capture of redirects that arrive while the PC cannot advance.
- Sits at the head of the fetch stage and drives the instruction pointer into instruction memory.

Parameters:
ADDR_W, 16, instruction-address width in bits
DISP_W, 8, branch displacement width; signed two's complement; must satisfy DISP_W <= ADDR_W
RESET_VEC, 0, address loaded on reset, ADDR_W bits
RAS_DEPTH, 4, return-address-stack entries; power of two, >= 2; used only with PC_RAS_EN

Ports:
clk_i  input  1  clock, rising edge
rst_ni  input  1  reset, asynchronous, active-low
stall_i  input  1  pipeline stall; holds PC
jump_i  input  1  absolute redirect request
branch_i  input  1  taken-branch request, PC-relative
displacement_i  input  DISP_W  signed branch offset, relative to current addr_imem_o
jump_tgt_i  input  ADDR_W  absolute jump target
imem_ready_i  input  1  instruction memory accepts addr_imem_o this cycle
call_i  input  1  with jump_i: push return address (PC_RAS_EN only)
ret_i  input  1  pop return address as target (PC_RAS_EN only)
addr_imem_o  output  ADDR_W  instruction pointer
addr_valid_o  output  1  addr_imem_o is a valid fetch request
redirect_pend_o  output  1  a captured redirect is waiting to be applied
ras_empty_o  output  1  return-address stack empty
ras_full_o  output  1  return-address stack full

Behaviour:
- Reset (rst_ni low, asynchronous):
  - addr_imem_o = RESET_VEC, addr_valid_o = 0, redirect_pend_o = 0.
  - FSM = BOOT; RAS emptied (ras_empty_o = 1, ras_full_o = 0).
  - Reset mid-operation discards any pending redirect and all RAS contents.
- FSM states:
  - BOOT: addr_valid_o = 0; always moves to RUN on the next edge. Redirect inputs are ignored in BOOT.
  - RUN: addr_valid_o = 1.
- Advance condition: adv = addr_valid_o & imem_ready_i & ~stall_i.
- Sign extension: disp_ext = displacement_i sign-extended to ADDR_W.
- Redirect target, evaluated in the cycle the request is seen:
  - ret_i (PC_RAS_EN, RAS not empty): top of stack.
  - else jump_i: jump_tgt_i.
  - else branch_i: addr_imem_o + disp_ext.
  - Priority is ret > jump > branch; simultaneous requests select the highest.
- Next-PC selection when adv = 1, all updates taking effect on the next edge:
  - Live redirect present: PC <= redirect target.
  - Else redirect_pend_o = 1: PC <= pending target, and redirect_pend_o clears.
  - Else: PC <= addr_imem_o + 1.
- When adv = 0 and a redirect request is present:
  - The target is latched into the pending register and redirect_pend_o is set on the next edge.
  - A later request overwrites an older pending target (latest wins).
  - PC holds.
- When adv = 0 with no request, PC and pending state hold.
- Arithmetic is modulo 2^ADDR_W. Wrap-around is silent: 0xFFFF + 1 = 0x0000, and 0x0002 + (-4) = 0xFFFE.
- Latency: a redirect seen in a cycle with adv = 1 appears on addr_imem_o on the next edge.

Optional Feature:
- Macro: PC_RAS_EN.
- Defined:
  - RAS_DEPTH-entry circular return-address stack.
  - jump_i & call_i pushes addr_imem_o + 1 (modulo) when the redirect is accepted or captured.
  - Push when full overwrites the oldest entry; ras_full_o stays 1.
  - ret_i pops the top entry and uses it as the target.
  - ret_i while empty is ignored: lower-priority requests or sequential flow proceed, and ras_empty_o stays 1.
  - call and ret in the same cycle: ret pops first, then the push occurs; net occupancy is unchanged.
  - A pop consumed by a captured redirect is not undone if a later request overwrites that pending target.
- Not defined:
  - call_i and ret_i are ignored; ras_empty_o = 1 and ras_full_o = 0 constantly.
  - No stack storage is synthesised.

Test Plan (ADDR_W=16, DISP_W=8, RESET_VEC=0x0100):
1. Reset, then imem_ready_i=1 with no requests -> addr_valid_o 0 for one cycle at 0x0100, then addresses 0x0100, 0x0101, 0x0102 on successive cycles.
2. PC=0x0010, branch_i=1, displacement_i=0xFC -> next addr 0x000C; same from PC=0x0002 -> 0xFFFE (wrap).
3. jump_i=1 and branch_i=1 together, jump_tgt_i=0x4000 -> next addr 0x4000.
4. imem_ready_i=0 at PC=0x0020, jump_i=1 with tgt 0x0300, then branch_i with disp 0x05 one cycle later, then ready=1 -> redirect_pend_o high while waiting; next addr 0x0025 (latest wins); pend clears.
5. rst_ni asserted low mid-cycle while redirect_pend_o=1 -> outputs immediately RESET_VEC, valid 0, pend 0.
6. (PC_RAS_EN, RAS_DEPTH=4) Five calls from 0x0010, 0x0020, 0x0030, 0x0040, 0x0050, then four rets -> returns 0x0051, 0x0041, 0x0031, 0x0021; ras_empty_o=1 after the fourth; a fifth ret gives sequential flow.
